axi_4kb_split_ctrl: RTL and testbench
=====================================

# axi_4kb_split_ctrl

Sequencer for the 4KB-boundary splitting stage on one AXI4 address channel (AW or AR) of the interconnect. It accepts one master address request at a time and detects whether an INCR burst crosses a 4KB page. Crossing requests go out as two legal sub-requests in order; all others pass through unchanged. An optional info stream tells the downstream response merger whether each original request was split.

## Interface
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, AxLEN width
- SIZE_WIDTH, 3, AxSIZE width
- ID_WIDTH, 4, AxID width
- ACLK_i  in  1  clock
- ARESET_i  in  1  reset; asynchronous and active-high
- s_ADDR_i / s_LEN_i / s_SIZE_i / s_BURST_i / s_ID_i  in  ADDR_WIDTH / LEN_WIDTH / SIZE_WIDTH / 2 / ID_WIDTH  upstream request fields
- s_valid_i  in  1; s_ready_o  out  1  upstream handshake
- m_ADDR_o / m_LEN_o / m_SIZE_o / m_BURST_o / m_ID_o  out  same widths  sub-request fields
- m_last_o  out  1  current sub-request is the final one of its original request
- m_valid_o  out  1; m_ready_i  in  1  downstream handshake
- info_valid_o  out  1; info_ready_i  in  1; info_split_o  out  1; info_ID_o  out  ID_WIDTH  split-info stream (AXI_SPLIT_INFO_EN only)

## Operation
- States: IDLE, FIRST, SECOND.
- **IDLE**: s_ready_o=1. When s_valid_i=1:
  - register all fields and the split decision;
  - go to FIRST.
- **FIRST**: m_valid_o=1.
  - m_ADDR_o = original ADDR.
  - m_LEN_o = LEN1 if split, else the original LEN.
  - m_last_o = !split.
  - On m_ready_i: go to SECOND if split. Otherwise go to IDLE, or stay in FIRST if a new request is accepted in the same cycle.
- **SECOND**: m_valid_o=1, m_ADDR_o={ADDR[ADDR_WIDTH-1:12]+1, 12'h000}, m_LEN_o=LEN2, m_last_o=1.
  - On m_ready_i: go to IDLE, or to FIRST if a new request is accepted in the same cycle.
- **Passthrough**: SIZE, BURST and ID are passed unchanged on every sub-request.
- **Early accept**: s_ready_o is also 1 in the cycle where m_valid_o & m_ready_i & m_last_o.
- **Arithmetic**:
  - bytes = (LEN+1) << SIZE, computed LEN_WIDTH+8 bits wide.
  - off = ADDR[11:0] with the low SIZE bits cleared.
  - split = (BURST==INCR) & (off + bytes > 4096) & (bytes <= 4096).
  - beats1 = (4096 - off) >> SIZE; LEN1 = beats1 - 1; LEN2 = LEN - beats1.
- **Boundary cases**:
  - A burst ending exactly on the 4KB boundary is not split.
  - FIXED and WRAP bursts are never split.
  - bytes > 4096 (illegal per AXI) is forwarded unsplit and never hangs.
- **Info stream**: with AXI_SPLIT_INFO_EN, every accepted request loads a 1-entry info register {split, ID} and raises info_valid_o. While info_valid_o & !info_ready_i, s_ready_o=0.
- Sub-requests are never reordered or interleaved; SECOND always directly follows FIRST.

## Timing
- **Reset**: state=IDLE; m_valid_o=0, info_valid_o=0, m_last_o=0; all m_* and info_* data outputs 0; s_ready_o=1 after reset deasserts.
- **Reset mid-operation**: aborts the request and discards any pending SECOND; no partial replay.
- **Latency**: accept at cycle N -> m_valid_o at N+1.
- **Throughput**: back-to-back non-split requests run at 1 per cycle when m_ready_i=1; a split request occupies 2 output cycles.
- **Stability**: all m_* outputs are registered and held stable while m_valid_o & !m_ready_i. m_valid_o never drops without a handshake.
- **Combinational paths**: s_ready_o depends combinationally on m_ready_i (and on info_ready_i when the info stream is enabled). No other combinational input-to-output path exists.

## Configuration
- AXI_SPLIT_INFO_EN defined: the info_* ports and the info register exist, and s_ready_o is gated by info-register occupancy as described in Operation.
- Not defined: the info_* ports are absent and s_ready_o ignores the info path. Everything else is identical.

## Structure
- Shared package axi_split_pkg holds:
  - BURST encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10);
  - the state enum;
  - BOUNDARY_4KB=4096 and BIT_OFFSET_4KB=12.
- One sub-module, axi_4kb_boundary_calc: combinational; computes split, LEN1, LEN2 and ADDR2 from the registered request. The controller owns the FSM and all registers.

## Test plan
- ADDR=0x0000_0FF0, LEN=3, SIZE=3, INCR -> two sub-requests: {0x0FF0, LEN 1, last=0} then {0x1000, LEN 1, last=1}; info_split=1.
- ADDR=0x0000_0FE0, LEN=3, SIZE=3 (ends exactly at 0x1000) -> one request {0x0FE0, LEN 3, last=1}; info_split=0.
- Unaligned ADDR=0x0000_0FFC, LEN=1, SIZE=3 -> {0x0FFC, LEN 0} then {0x1000, LEN 0}.
- WRAP burst at ADDR=0x0FF0, LEN=3, SIZE=3 -> passed unsplit. Then 4 non-split requests back-to-back with m_ready_i=1 -> 4 outputs in 4 consecutive cycles.
- Hold m_ready_i=0 for 5 cycles during FIRST of a split request -> outputs stable, s_ready_o=0; SECOND follows on the cycle after the first handshake.
- Assert ARESET_i while in SECOND -> m_valid_o=0 immediately, state IDLE; the next accepted request behaves normally.

Source files
------------

// File: rtl/axi_split_pkg.sv
// axi_split_pkg: shared types and constants for the AXI 4KB-boundary split stage.
// Holds the AXI burst encodings, the split-controller state enum and the 4KB page constants.
package axi_split_pkg;

   // A 4KB page: its size in bytes and the address bit where the page number starts.
   localparam int BOUNDARY_4KB   = 4096;
   localparam int BIT_OFFSET_4KB = 12;

   // AXI AxBURST encodings.
   typedef enum logic [1:0] {
      FIXED    = 2'b00,
      INCR     = 2'b01,
      WRAP     = 2'b10,
      RESERVED = 2'b11
   } burst_e;

   // Split controller sequencing: FIRST always carries the original address,
   // SECOND only exists for requests that cross a page.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FIRST  = 2'b01,
      SECOND = 2'b10
   } state_e;

endpackage

// File: rtl/axi_4kb_split_ctrl_if.sv
// axi_4kb_split_ctrl_if: upstream request, downstream sub-request and (optional)
// split-info signals of the 4KB split stage.
// Optional feature macro: AXI_SPLIT_INFO_EN adds the info_* stream signals.
// The slave modport is the split controller's view; master is the surrounding fabric's view.
interface axi_4kb_split_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int SIZE_WIDTH = 3,
   parameter int ID_WIDTH   = 4
);

   // Upstream request channel.
   logic [ADDR_WIDTH-1:0] s_ADDR_i;
   logic [LEN_WIDTH-1:0]  s_LEN_i;
   logic [SIZE_WIDTH-1:0] s_SIZE_i;
   logic [1:0]            s_BURST_i;
   logic [ID_WIDTH-1:0]   s_ID_i;
   logic                  s_valid_i;
   logic                  s_ready_o;

   // Downstream sub-request channel.
   logic [ADDR_WIDTH-1:0] m_ADDR_o;
   logic [LEN_WIDTH-1:0]  m_LEN_o;
   logic [SIZE_WIDTH-1:0] m_SIZE_o;
   logic [1:0]            m_BURST_o;
   logic [ID_WIDTH-1:0]   m_ID_o;
   logic                  m_last_o;
   logic                  m_valid_o;
   logic                  m_ready_i;

`ifdef AXI_SPLIT_INFO_EN
   // Split-info stream towards the response merger.
   logic                  info_valid_o;
   logic                  info_ready_i;
   logic                  info_split_o;
   logic [ID_WIDTH-1:0]   info_ID_o;
`endif

   modport slave (
      input  s_ADDR_i, s_LEN_i, s_SIZE_i, s_BURST_i, s_ID_i, s_valid_i,
      input  m_ready_i,
`ifdef AXI_SPLIT_INFO_EN
      input  info_ready_i,
      output info_valid_o, info_split_o, info_ID_o,
`endif
      output s_ready_o,
      output m_ADDR_o, m_LEN_o, m_SIZE_o, m_BURST_o, m_ID_o, m_last_o, m_valid_o
   );

   modport master (
      output s_ADDR_i, s_LEN_i, s_SIZE_i, s_BURST_i, s_ID_i, s_valid_i,
      output m_ready_i,
`ifdef AXI_SPLIT_INFO_EN
      output info_ready_i,
      input  info_valid_o, info_split_o, info_ID_o,
`endif
      input  s_ready_o,
      input  m_ADDR_o, m_LEN_o, m_SIZE_o, m_BURST_o, m_ID_o, m_last_o, m_valid_o
   );

endinterface

// File: rtl/axi_4kb_boundary_calc.sv
// axi_4kb_boundary_calc: purely combinational 4KB page-crossing arithmetic.
// Given one registered request it decides whether an INCR burst crosses a 4KB page
// and, if so, how the beats divide between the two legal sub-requests.
module axi_4kb_boundary_calc
   import axi_split_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int SIZE_WIDTH = 3
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic [SIZE_WIDTH-1:0] size_i,
   input  logic [1:0]            burst_i,
   output logic                  split_o,
   output logic [LEN_WIDTH-1:0]  len1_o,
   output logic [LEN_WIDTH-1:0]  len2_o,
   output logic [ADDR_WIDTH-1:0] addr2_o
);

   // Byte count is wide enough for 256 beats of 128 bytes; the sum gets one carry bit more.
   localparam int BYTES_W = LEN_WIDTH + 8;
   localparam int SUM_W   = BYTES_W + 1;
   localparam int PAGE_W  = ADDR_WIDTH - BIT_OFFSET_4KB;

   logic [BYTES_W-1:0]        bytes;
   logic [BIT_OFFSET_4KB-1:0] size_mask;
   logic [BIT_OFFSET_4KB-1:0] off;
   logic [SUM_W-1:0]          end_sum;
   logic [BIT_OFFSET_4KB:0]   room;
   logic [BIT_OFFSET_4KB:0]   beats1;
   logic [PAGE_W-1:0]         page_next;

   // Burst footprint, aligned page offset and the split decision.
   always_comb begin
      bytes     = ({8'd0, len_i} + BYTES_W'(1)) << size_i;
      size_mask = (BIT_OFFSET_4KB'(1) << size_i) - BIT_OFFSET_4KB'(1);
      off       = addr_i[BIT_OFFSET_4KB-1:0] & ~size_mask;
      end_sum   = SUM_W'(off) + SUM_W'(bytes);
      // Ending exactly on the boundary is legal; oversize bursts are illegal AXI and
      // are forwarded untouched rather than split into something still illegal.
      split_o   = (burst_i == INCR)
                  && (end_sum > SUM_W'(BOUNDARY_4KB))
                  && (bytes <= BYTES_W'(BOUNDARY_4KB));
   end

   // Beat distribution and the page-aligned start of the second sub-request.
   always_comb begin
      // off is size-aligned, so room is a whole number of beats and beats1 >= 1.
      room      = (BIT_OFFSET_4KB + 1)'(BOUNDARY_4KB) - {1'b0, off};
      beats1    = room >> size_i;
      len1_o    = LEN_WIDTH'(beats1 - (BIT_OFFSET_4KB + 1)'(1));
      len2_o    = len_i - LEN_WIDTH'(beats1);
      page_next = addr_i[ADDR_WIDTH-1:BIT_OFFSET_4KB] + PAGE_W'(1);
      addr2_o   = {page_next, {BIT_OFFSET_4KB{1'b0}}};
   end

endmodule

// File: rtl/axi_4kb_split_ctrl.sv
// axi_4kb_split_ctrl: 4KB-boundary splitting sequencer for one AXI4 address channel.
// Accepts one request at a time, emits it unchanged or as two page-legal sub-requests,
// and overlaps the next accept with the final sub-request handshake.
// Optional feature macro: AXI_SPLIT_INFO_EN adds a 1-entry {split, ID} info stream
// for the response merger; a pending entry back-pressures the upstream channel.
module axi_4kb_split_ctrl
   import axi_split_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int SIZE_WIDTH = 3,
   parameter int ID_WIDTH   = 4
) (
   input  logic                ACLK_i,
   input  logic                ARESET_i,
   axi_4kb_split_ctrl_if.slave bus
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;

   logic                  split;
   logic [LEN_WIDTH-1:0]  len1;
   logic [LEN_WIDTH-1:0]  len2;
   logic [ADDR_WIDTH-1:0] addr2;

   logic                  m_valid;
   logic                  m_last;
   logic                  out_done;
   logic                  info_free;
   logic                  s_ready;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [LEN_WIDTH-1:0]  m_len;

`ifdef AXI_SPLIT_INFO_EN
   logic                  info_valid_q, info_valid_d;
`endif

   // Page-crossing arithmetic always works on the held request, so every m_* output
   // is a function of registers only.
   axi_4kb_boundary_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .SIZE_WIDTH (SIZE_WIDTH)
   ) u_calc (
      .addr_i  (addr_q),
      .len_i   (len_q),
      .size_i  (size_q),
      .burst_i (burst_q),
      .split_o (split),
      .len1_o  (len1),
      .len2_o  (len2),
      .addr2_o (addr2)
   );

   // Handshake qualifiers: when the current request finishes and when a new one is taken.
   always_comb begin
      m_valid  = (state_q != IDLE);
      m_last   = (state_q == SECOND) || ((state_q == FIRST) && !split);
      out_done = m_valid && bus.m_ready_i && m_last;
`ifdef AXI_SPLIT_INFO_EN
      info_free = !info_valid_q || bus.info_ready_i;
`else
      info_free = 1'b1;
`endif
      s_ready  = ((state_q == IDLE) || out_done) && info_free;
      accept   = bus.s_valid_i && s_ready;
   end

   // Next-state logic: FIRST -> SECOND for split requests, otherwise back to IDLE
   // or straight into FIRST when a new request is taken on the final handshake.
   always_comb begin
      // NOTE: defaults first, so no branch leaves state_d unassigned and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FIRST;
            end
         end
         FIRST: begin
            if (bus.m_ready_i) begin
               if (split) begin
                  state_d = SECOND;
               end else if (accept) begin
                  state_d = FIRST;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         SECOND: begin
            if (bus.m_ready_i) begin
               state_d = accept ? FIRST : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any request in flight, including a pending SECOND.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (ARESET_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture: the fields only change on an accepted upstream handshake.
   always_comb begin
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      id_d    = id_q;
      if (accept) begin
         addr_d  = bus.s_ADDR_i;
         len_d   = bus.s_LEN_i;
         size_d  = bus.s_SIZE_i;
         burst_d = bus.s_BURST_i;
         id_d    = bus.s_ID_i;
      end
   end

   // Request register; cleared on reset so the data outputs read zero until the first accept.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         id_q    <= '0;
      end else begin
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         id_q    <= id_d;
      end
   end

`ifdef AXI_SPLIT_INFO_EN
   // Info entry occupancy: set on every accept, cleared when the merger takes it.
   always_comb begin
      info_valid_d = info_valid_q;
      if (accept) begin
         info_valid_d = 1'b1;
      end else if (bus.info_ready_i) begin
         info_valid_d = 1'b0;
      end
   end

   // Info entry register.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         info_valid_q <= 1'b0;
      end else begin
         info_valid_q <= info_valid_d;
      end
   end

   // The held request cannot be replaced while its info entry is still pending
   // (s_ready is blocked), so the entry's {split, ID} payload is read from it directly.
   assign bus.info_valid_o = info_valid_q;
   assign bus.info_split_o = split;
   assign bus.info_ID_o    = id_q;
`endif

   // Sub-request address/length: original address first, next page base second.
   always_comb begin
      m_addr = addr_q;
      m_len  = len_q;
      if (state_q == FIRST && split) begin
         m_len = len1;
      end
      if (state_q == SECOND) begin
         m_addr = addr2;
         m_len  = len2;
      end
   end

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = m_valid;
   assign bus.m_last_o  = m_last;
   assign bus.m_ADDR_o  = m_addr;
   assign bus.m_LEN_o   = m_len;
   assign bus.m_SIZE_o  = size_q;
   assign bus.m_BURST_o = burst_q;
   assign bus.m_ID_o    = id_q;

endmodule

// File: tb/tb_axi_4kb_split_ctrl.sv
// tb_axi_4kb_split_ctrl: scoreboard bench for the 4KB split controller.
// Expected sub-requests are queued when a request is accepted and compared when the
// controller hands them downstream. With AXI_SPLIT_INFO_EN the info stream is scored too.
module tb_axi_4kb_split_ctrl;
   import axi_split_pkg::*;

   localparam int AW = 32;
   localparam int LW = 8;
   localparam int SW = 3;
   localparam int IW = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [SW-1:0] size;
      logic [1:0]    burst;
      logic [IW-1:0] id;
      logic          last;
   } beat_t;

   logic ACLK_i = 1'b0;
   logic ARESET_i;

   axi_4kb_split_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW), .ID_WIDTH(IW)) bus_if ();

   axi_4kb_split_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW), .ID_WIDTH(IW)) dut (
      .ACLK_i   (ACLK_i),
      .ARESET_i (ARESET_i),
      .bus      (bus_if)
   );

   always #5 ACLK_i = ~ACLK_i;

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   beat_t sb_q[$];
   beat_t stage_q[$];
   int    hs_q[$];
   logic  accepted;
`ifdef AXI_SPLIT_INFO_EN
   logic [IW:0] info_exp_q[$];
   logic [IW:0] info_stage;
`endif

   function automatic beat_t mk(input logic [AW-1:0] a, input logic [LW-1:0] l,
                                input logic [SW-1:0] s, input logic [1:0] b,
                                input logic [IW-1:0] id, input logic last);
      return {a, l, s, b, id, last};
   endfunction

   // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
   task automatic tick();
      beat_t act;
      beat_t exp;
      @(negedge ACLK_i);
      if (bus_if.m_valid_o && bus_if.m_ready_i) begin
         act = {bus_if.m_ADDR_o, bus_if.m_LEN_o, bus_if.m_SIZE_o, bus_if.m_BURST_o,
                bus_if.m_ID_o, bus_if.m_last_o};
         hs_q.push_back(cyc);
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected sub-request addr=%h len=%0d last=%0b while none required",
                     act.addr, act.len, act.last);
         end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
               errors++;
               $display("FAIL beat: got addr=%h len=%0d size=%0d burst=%0d id=%0d last=%0b, required addr=%h len=%0d size=%0d burst=%0d id=%0d last=%0b",
                        act.addr, act.len, act.size, act.burst, act.id, act.last,
                        exp.addr, exp.len, exp.size, exp.burst, exp.id, exp.last);
            end
         end
      end
`ifdef AXI_SPLIT_INFO_EN
      if (bus_if.info_valid_o && bus_if.info_ready_i) begin
         checks++;
         if (info_exp_q.size() == 0) begin
            errors++;
            $display("FAIL info: unexpected entry split=%0b id=%0d", bus_if.info_split_o, bus_if.info_ID_o);
         end else if ({bus_if.info_split_o, bus_if.info_ID_o} !== info_exp_q[0]) begin
            errors++;
            $display("FAIL info: got split=%0b id=%0d, required %b", bus_if.info_split_o,
                     bus_if.info_ID_o, info_exp_q[0]);
            void'(info_exp_q.pop_front());
         end else begin
            void'(info_exp_q.pop_front());
         end
      end
`endif
      accepted = 1'b0;
      if (bus_if.s_valid_i && bus_if.s_ready_o) begin
         accepted = 1'b1;
         foreach (stage_q[i]) sb_q.push_back(stage_q[i]);
`ifdef AXI_SPLIT_INFO_EN
         info_exp_q.push_back(info_stage);
`endif
      end
      @(posedge ACLK_i);
      cyc++;
      #1;
   endtask

   // Present one request and hold it until accepted; stage_q holds its expected sub-requests.
   task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [SW-1:0] s,
                       input logic [1:0] b, input logic [IW-1:0] id, input logic sp);
      int n;
      n = 0;
      bus_if.s_ADDR_i  = a;
      bus_if.s_LEN_i   = l;
      bus_if.s_SIZE_i  = s;
      bus_if.s_BURST_i = b;
      bus_if.s_ID_i    = id;
      bus_if.s_valid_i = 1'b1;
`ifdef AXI_SPLIT_INFO_EN
      info_stage = {sp, id};
`endif
      do begin
         tick();
         n++;
      end while (!accepted && n < 50);
      bus_if.s_valid_i = 1'b0;
      stage_q.delete();
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL accept: request addr=%h still not accepted after %0d cycles (split=%0b)", a, n, sp);
      end
   endtask

   // Run until every expected sub-request has been seen, within a cycle budget.
   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d sub-requests still outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      ARESET_i            = 1'b1;
      bus_if.s_valid_i    = 1'b0;
      bus_if.s_ADDR_i     = '0;
      bus_if.s_LEN_i      = '0;
      bus_if.s_SIZE_i     = '0;
      bus_if.s_BURST_i    = '0;
      bus_if.s_ID_i       = '0;
      bus_if.m_ready_i    = 1'b0;
`ifdef AXI_SPLIT_INFO_EN
      bus_if.info_ready_i = 1'b1;
`endif
      repeat (3) @(posedge ACLK_i);
      #1;
      checks++;
      if (bus_if.m_valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_m_valid: got %b required 0", bus_if.m_valid_o);
      end
      checks++;
      if (bus_if.m_last_o !== 1'b0) begin
         errors++; $display("FAIL reset_m_last: got %b required 0", bus_if.m_last_o);
      end
      checks++;
      if (bus_if.m_ADDR_o !== '0 || bus_if.m_LEN_o !== '0) begin
         errors++; $display("FAIL reset_addr_len: got %h/%h required 0/0", bus_if.m_ADDR_o, bus_if.m_LEN_o);
      end
      checks++;
      if ({bus_if.m_SIZE_o, bus_if.m_BURST_o, bus_if.m_ID_o} !== '0) begin
         errors++; $display("FAIL reset_size_burst_id: got %h required 0",
                            {bus_if.m_SIZE_o, bus_if.m_BURST_o, bus_if.m_ID_o});
      end
`ifdef AXI_SPLIT_INFO_EN
      checks++;
      if ({bus_if.info_valid_o, bus_if.info_split_o, bus_if.info_ID_o} !== '0) begin
         errors++; $display("FAIL reset_info: got %b required 0",
                            {bus_if.info_valid_o, bus_if.info_split_o, bus_if.info_ID_o});
      end
`endif
      ARESET_i = 1'b0;
      #1;
      checks++;
      if (bus_if.s_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_s_ready: got %b required 1", bus_if.s_ready_o);
      end
   endtask

   task automatic test_split_basic();
      bus_if.m_ready_i = 1'b1;
      stage_q.push_back(mk(32'h0000_0FF0, 8'd1, 3'd3, INCR, 4'h1, 1'b0));
      stage_q.push_back(mk(32'h0000_1000, 8'd1, 3'd3, INCR, 4'h1, 1'b1));
      send(32'h0000_0FF0, 8'd3, 3'd3, INCR, 4'h1, 1'b1);
      drain();
      // Higher page: 17 beats of 4 bytes from offset 0xFC0, 16 fit in the first page.
      stage_q.push_back(mk(32'h1234_5FC0, 8'd15, 3'd2, INCR, 4'hB, 1'b0));
      stage_q.push_back(mk(32'h1234_6000, 8'd0,  3'd2, INCR, 4'hB, 1'b1));
      send(32'h1234_5FC0, 8'd16, 3'd2, INCR, 4'hB, 1'b1);
      drain();
   endtask

   task automatic test_exact_boundary();
      bus_if.m_ready_i = 1'b1;
      stage_q.push_back(mk(32'h0000_0FE0, 8'd3, 3'd3, INCR, 4'h2, 1'b1));
      send(32'h0000_0FE0, 8'd3, 3'd3, INCR, 4'h2, 1'b0);
      drain();
   endtask

   task automatic test_unaligned();
      bus_if.m_ready_i = 1'b1;
      stage_q.push_back(mk(32'h0000_0FFC, 8'd0, 3'd3, INCR, 4'h3, 1'b0));
      stage_q.push_back(mk(32'h0000_1000, 8'd0, 3'd3, INCR, 4'h3, 1'b1));
      send(32'h0000_0FFC, 8'd1, 3'd3, INCR, 4'h3, 1'b1);
      drain();
   endtask

   task automatic test_non_incr();
      bus_if.m_ready_i = 1'b1;
      stage_q.push_back(mk(32'h0000_0FF0, 8'd3, 3'd3, WRAP, 4'h4, 1'b1));
      send(32'h0000_0FF0, 8'd3, 3'd3, WRAP, 4'h4, 1'b0);
      drain();
      stage_q.push_back(mk(32'h0000_0FFC, 8'd7, 3'd2, FIXED, 4'h5, 1'b1));
      send(32'h0000_0FFC, 8'd7, 3'd2, FIXED, 4'h5, 1'b0);
      drain();
   endtask

   task automatic test_oversize();
      // 256 beats of 32 bytes = 8KB: illegal, forwarded as-is.
      bus_if.m_ready_i = 1'b1;
      stage_q.push_back(mk(32'h0000_1F80, 8'd255, 3'd5, INCR, 4'h6, 1'b1));
      send(32'h0000_1F80, 8'd255, 3'd5, INCR, 4'h6, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      bus_if.m_ready_i = 1'b1;
      hs_q.delete();
      for (int i = 0; i < 4; i++) begin
         bus_if.s_ADDR_i  = 32'h0000_0100 * (i + 1);
         bus_if.s_LEN_i   = LW'(i);
         bus_if.s_SIZE_i  = 3'd2;
         bus_if.s_BURST_i = INCR;
         bus_if.s_ID_i    = IW'(8 + i);
         bus_if.s_valid_i = 1'b1;
`ifdef AXI_SPLIT_INFO_EN
         info_stage = {1'b0, IW'(8 + i)};
`endif
         stage_q.delete();
         stage_q.push_back(mk(32'h0000_0100 * (i + 1), LW'(i), 3'd2, INCR, IW'(8 + i), 1'b1));
         tick();
         checks++;
         if (!accepted) begin
            errors++; $display("FAIL b2b_accept: request %0d not accepted in its cycle", i);
         end
      end
      bus_if.s_valid_i = 1'b0;
      stage_q.delete();
      drain();
      checks++;
      if (hs_q.size() != 4) begin
         errors++; $display("FAIL b2b_count: got %0d handshakes required 4", hs_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (hs_q[i] - hs_q[i-1] != 1) begin
               errors++; $display("FAIL b2b_gap: output %0d came %0d cycles after previous, required 1",
                                  i, hs_q[i] - hs_q[i-1]);
            end
         end
      end
   endtask

   task automatic test_stall();
      bus_if.m_ready_i = 1'b0;
      stage_q.push_back(mk(32'h0000_5FF0, 8'd1, 3'd3, INCR, 4'h7, 1'b0));
      stage_q.push_back(mk(32'h0000_6000, 8'd1, 3'd3, INCR, 4'h7, 1'b1));
      send(32'h0000_5FF0, 8'd3, 3'd3, INCR, 4'h7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus_if.m_valid_o !== 1'b1) begin
            errors++; $display("FAIL stall_valid: cycle %0d got %b required 1", i, bus_if.m_valid_o);
         end
         checks++;
         if ({bus_if.m_ADDR_o, bus_if.m_LEN_o, bus_if.m_last_o} !== {32'h0000_5FF0, 8'd1, 1'b0}) begin
            errors++; $display("FAIL stall_hold: cycle %0d got addr=%h len=%0d last=%0b required 5ff0/1/0",
                               i, bus_if.m_ADDR_o, bus_if.m_LEN_o, bus_if.m_last_o);
         end
         checks++;
         if (bus_if.s_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_s_ready: cycle %0d got %b required 0", i, bus_if.s_ready_o);
         end
         tick();
      end
      hs_q.delete();
      bus_if.m_ready_i = 1'b1;
      tick();
      tick();
      checks++;
      if (hs_q.size() != 2) begin
         errors++; $display("FAIL stall_second: got %0d handshakes in 2 cycles required 2", hs_q.size());
      end else if (hs_q[1] - hs_q[0] != 1) begin
         errors++; $display("FAIL stall_second: SECOND %0d cycles after FIRST required 1", hs_q[1] - hs_q[0]);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      // Only the FIRST sub-request is expected: reset lands while SECOND is pending.
      bus_if.m_ready_i = 1'b0;
      stage_q.push_back(mk(32'h0000_2FF8, 8'd1, 3'd2, INCR, 4'h9, 1'b0));
      send(32'h0000_2FF8, 8'd3, 3'd2, INCR, 4'h9, 1'b1);
      bus_if.m_ready_i = 1'b1;
      tick();
      bus_if.m_ready_i = 1'b0;
      checks++;
      if (bus_if.m_valid_o !== 1'b1 || bus_if.m_ADDR_o !== 32'h0000_3000) begin
         errors++; $display("FAIL mid_second: got valid=%b addr=%h required 1/00003000",
                            bus_if.m_valid_o, bus_if.m_ADDR_o);
      end
      ARESET_i = 1'b1;
      #1;
      checks++;
      if (bus_if.m_valid_o !== 1'b0 || bus_if.m_last_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got valid=%b last=%b required 0/0",
                            bus_if.m_valid_o, bus_if.m_last_o);
      end
      bus_if.m_ready_i = 1'b1;
      tick();
      tick();
      ARESET_i = 1'b0;
      tick();
      checks++;
      if (bus_if.m_valid_o !== 1'b0 || bus_if.s_ready_o !== 1'b1) begin
         errors++; $display("FAIL mid_idle: got valid=%b s_ready=%b required 0/1",
                            bus_if.m_valid_o, bus_if.s_ready_o);
      end
      stage_q.push_back(mk(32'h0000_3000, 8'd0, 3'd2, INCR, 4'hA, 1'b1));
      send(32'h0000_3000, 8'd0, 3'd2, INCR, 4'hA, 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_split_basic();
      test_exact_boundary();
      test_unaligned();
      test_non_incr();
      test_oversize();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      repeat (3) tick();
`ifdef AXI_SPLIT_INFO_EN
      checks++;
      if (info_exp_q.size() != 0) begin
         errors++; $display("FAIL info_drain: %0d info entries never delivered", info_exp_q.size());
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute backstop in case a wait is ever left unbounded.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
